// File: rtl/mem_arbiter.sv
// Arbiter between instruction fetch and data access for a single-ported, variable-latency word RAM.
// Data has priority; a starvation counter forces a fetch through after STARVE_MAX data grants.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        ramREN,
    output logic        ramWEN,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IACC = 2'b01,
        DACC = 2'b10
    } state_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e     state_q, state_d;
    logic [3:0] icount_q, icount_d;
    logic       dreq;

    assign dreq = dREN | dWEN;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        icount_d = icount_q;
        unique case (state_q)
            IDLE: begin
                if (dreq && !(iREN && icount_q == STARVE_LIM)) begin
                    state_d = DACC;
                    if (iREN && icount_q != STARVE_LIM) begin
                        icount_d = icount_q + 4'd1;
                    end
                end else if (iREN) begin
                    state_d  = IACC;
                    icount_d = 4'd0;
                end
            end
            IACC: begin
                if (ram_ready || !iREN) begin
                    state_d = IDLE;
                end
            end
            DACC: begin
                if (ram_ready || !dreq) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            icount_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            icount_q <= icount_d;
        end
    end

    // RAM-side outputs decode directly from the grant so reset drops the strobes at once.
    always_comb begin
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        unique case (state_q)
            IACC: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                ihit    = ram_ready;
            end
            DACC: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dhit     = ram_ready;
            end
            default: ;
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;
    assign grant = state_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with hand-written starvation and reset sequences.
module tb_mem_arbiter;

    localparam logic [31:0] IADDR  = 32'h0000_0040;
    localparam logic [31:0] DADDR  = 32'h0000_0100;
    localparam logic [31:0] DSTORE = 32'hDEAD_BEEF;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        ihit, dhit, ramREN, ramWEN, busy;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.STARVE_MAX(3)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dhit(dhit),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramload(ramload), .ram_ready(ram_ready),
        .grant(grant), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        iren, dren, dwen, rdy;
        logic [31:0] rload;
        logic [1:0]  grant;
        logic        ihit, dhit, rren, rwen;
    } vec_t;

    vec_t vecs[20];

    initial begin
        logic [31:0] exp_addr, exp_store;
        logic [1:0]  st_grant[10];
        logic        st_ihit[10];
        logic        st_dhit[10];

        // Fetch with 2 wait states, data priority, write-over-read, abort, ram_ready in IDLE.
        vecs[0]  = '{1,0,0,0, 32'h0,          2'd0, 0,0,0,0};
        vecs[1]  = '{1,0,0,0, 32'h1111_1111,  2'd1, 0,0,1,0};
        vecs[2]  = '{1,0,0,0, 32'h2222_2222,  2'd1, 0,0,1,0};
        vecs[3]  = '{1,0,0,1, 32'h8C01_0004,  2'd1, 1,0,1,0};
        vecs[4]  = '{0,0,0,0, 32'h0,          2'd0, 0,0,0,0};
        vecs[5]  = '{1,0,1,0, 32'h0,          2'd0, 0,0,0,0};
        vecs[6]  = '{1,0,1,1, 32'h3333_3333,  2'd2, 0,1,0,1};
        vecs[7]  = '{1,0,0,0, 32'h0,          2'd0, 0,0,0,0};
        vecs[8]  = '{1,0,0,1, 32'h1234_5678,  2'd1, 1,0,1,0};
        vecs[9]  = '{0,0,0,0, 32'h0,          2'd0, 0,0,0,0};
        vecs[10] = '{0,1,1,0, 32'h0,          2'd0, 0,0,0,0};
        vecs[11] = '{0,1,1,0, 32'h4444_4444,  2'd2, 0,0,0,1};
        vecs[12] = '{0,1,1,1, 32'hCAFE_F00D,  2'd2, 0,1,0,1};
        vecs[13] = '{0,0,0,0, 32'h0,          2'd0, 0,0,0,0};
        vecs[14] = '{1,0,0,0, 32'h0,          2'd0, 0,0,0,0};
        vecs[15] = '{1,0,0,0, 32'h5555_5555,  2'd1, 0,0,1,0};
        vecs[16] = '{0,1,0,0, 32'h6666_6666,  2'd1, 0,0,1,0};
        vecs[17] = '{0,1,0,0, 32'h0,          2'd0, 0,0,0,0};
        vecs[18] = '{0,1,0,1, 32'hA5A5_A5A5,  2'd2, 0,1,1,0};
        vecs[19] = '{0,0,0,1, 32'h55AA_55AA,  2'd0, 0,0,0,0};

        // Starvation pattern with STARVE_MAX=3: three D grants, one I grant, then D again.
        st_grant = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2};
        st_ihit  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        st_dhit  = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 1};

        iaddr = IADDR; daddr = DADDR; dstore = DSTORE;
        iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0; ramload = 32'h0;
        nRST = 0;
        #1;
        check("reset grant", 32'(grant), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset icount", 32'(dut.icount_q), 32'd0);
        check("reset strobes", {30'd0, ramREN, ramWEN}, 32'd0);
        repeat (2) @(negedge CLK);
        nRST = 1;

        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            iREN = vecs[i].iren; dREN = vecs[i].dren; dWEN = vecs[i].dwen;
            ram_ready = vecs[i].rdy; ramload = vecs[i].rload;
            #2;
            exp_addr  = (vecs[i].grant == 2'd1) ? IADDR : (vecs[i].grant == 2'd2) ? DADDR : 32'd0;
            exp_store = (vecs[i].grant == 2'd2) ? DSTORE : 32'd0;
            check($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].grant));
            check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].grant != 2'd0));
            check($sformatf("v%0d hits", i), {30'd0, ihit, dhit}, {30'd0, vecs[i].ihit, vecs[i].dhit});
            check($sformatf("v%0d strobes", i), {30'd0, ramREN, ramWEN}, {30'd0, vecs[i].rren, vecs[i].rwen});
            check($sformatf("v%0d ramaddr", i), ramaddr, exp_addr);
            check($sformatf("v%0d ramstore", i), ramstore, exp_store);
            check($sformatf("v%0d iload", i), iload, vecs[i].rload);
            check($sformatf("v%0d dload", i), dload, vecs[i].rload);
        end

        // Starvation: fetch and data read both held high against a zero-wait RAM.
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            iREN = 1; dREN = 1; dWEN = 0; ram_ready = 1; ramload = 32'h0BAD_0000 + 32'(i);
            #2;
            check($sformatf("starve%0d grant", i), 32'(grant), 32'(st_grant[i]));
            check($sformatf("starve%0d hits", i), {30'd0, ihit, dhit}, {30'd0, st_ihit[i], st_dhit[i]});
            if (i == 7) check("starve icount cleared", 32'(dut.icount_q), 32'd0);
            if (i == 9) check("starve icount restart", 32'(dut.icount_q), 32'd1);
        end

        // Reset mid-DACC with the RAM stalled.
        @(posedge CLK);
        #1;
        iREN = 1; dREN = 1; ram_ready = 0;
        @(posedge CLK);
        #3;
        check("pre-reset dacc", {30'd0, grant}, 32'd2);
        check("pre-reset icount", 32'(dut.icount_q), 32'd2);
        nRST = 0;
        #1;
        check("async reset strobes", {30'd0, ramREN, ramWEN}, 32'd0);
        check("async reset grant", 32'(grant), 32'd0);
        check("async reset hits", {30'd0, ihit, dhit}, 32'd0);
        check("async reset icount", 32'(dut.icount_q), 32'd0);
        iREN = 0; dREN = 0;
        @(negedge CLK);
        nRST = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #3;
            check($sformatf("post-reset%0d grant", i), 32'(grant), 32'd0);
            check($sformatf("post-reset%0d ihit", i), 32'(ihit), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the datapath's instruction-fetch and data-access requests onto a single-ported word RAM with variable latency. Requests are serialised through a three-state grant FSM. Data accesses have priority, and a starvation counter guarantees forward progress for fetch. Each access completes with a one-cycle `ihit`/`dhit` pulse, which the pipeline uses as its stall/advance qualifier.

## Interface
- `STARVE_MAX`, default 3: number of consecutive data grants issued while a fetch is pending before fetch is forced ahead; legal range 1–15.
- `CLK` in 1: system clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `iREN` in 1: instruction read request; held high until `ihit` or deasserted by flush.
- `iaddr` in 32: instruction word address.
- `iload` out 32: instruction read data; valid only while `ihit`=1.
- `ihit` out 1: instruction access complete.
- `dREN` in 1: data read request.
- `dWEN` in 1: data write request; takes precedence over `dREN` when both are high.
- `daddr` in 32: data word address.
- `dstore` in 32: data write value.
- `dload` out 32: data read data; valid only while `dhit`=1.
- `dhit` out 1: data access complete (read or write).
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramREN` out 1: RAM read strobe.
- `ramWEN` out 1: RAM write strobe.
- `ramload` in 32: RAM read data.
- `ram_ready` in 1: RAM access complete this cycle.
- `grant` out 2: current grant, encoded 00 IDLE, 01 IACC, 10 DACC.
- `busy` out 1: high whenever `grant` is not IDLE.

## Operation
- Registered state: FSM state (IDLE/IACC/DACC) and 4-bit `icount`. All other logic is combinational from the state and the inputs.
- **IDLE**
  - `dreq = dREN|dWEN`.
  - If `dreq` and not (`iREN` and `icount`==`STARVE_MAX`), go to DACC.
  - Otherwise, if `iREN`, go to IACC.
  - Otherwise, stay in IDLE.
- **`icount` update**, applied on each transition out of IDLE:
  - Entering DACC while `iREN`=1: `icount` increments, saturating at `STARVE_MAX`.
  - Entering IACC: `icount` clears to 0.
  - Entering DACC while `iREN`=0: `icount` is unchanged.
- **IACC**
  - Outputs: `ramaddr`=`iaddr`, `ramREN`=1, `ramWEN`=0, `ramstore`=0.
  - `ihit`=`ram_ready`, with `iload`=`ramload`.
  - On `ram_ready` or `iREN`=0, go to IDLE.
- **DACC**
  - Outputs: `ramaddr`=`daddr`, `ramstore`=`dstore`, `ramWEN`=`dWEN`, `ramREN`=`dREN & ~dWEN`.
  - `dhit`=`ram_ready`, with `dload`=`ramload`.
  - On `ram_ready` or `dreq`=0, go to IDLE.
- **IDLE outputs:** all RAM strobes are 0, `ramaddr`/`ramstore` are 0, and both hits are 0.
- **Abort:** when the granted requester drops its request before `ram_ready`, the FSM returns to IDLE without asserting a hit. `icount` is not changed.
- **`iload`/`dload`:** driven from `ramload` in every state; consumers qualify with the hit.
- The non-granted hit is always 0. `ihit` and `dhit` are never high in the same cycle.
- `ram_ready` is ignored in IDLE.

## Timing
- **Reset values (async, `nRST`=0):** state IDLE, `icount` 0, `grant` 00, `busy` 0, `ihit`/`dhit` 0, `ramREN`/`ramWEN` 0, `ramaddr`/`ramstore` 0. Reset asserted mid-access drops the strobes immediately; no hit is issued.
- **Latency:** a request first seen in IDLE in cycle 0 puts the strobe on the RAM in cycle 1. `ram_ready` in cycle 1 gives the hit in cycle 1, so the minimum request-to-hit latency is 2 cycles. Each wait cycle without `ram_ready` adds 1 cycle.
- **Post-completion idle cycle:** after every completion or abort there is one mandatory IDLE cycle. Back-to-back accesses therefore take a minimum of 2 cycles each, and the next grant is decided in that IDLE cycle.
- **Handshake:** a requester keeps its address, data and strobes stable from request until its hit. A request that is still high in the cycle after its hit is treated as a new request.
- **Simultaneous requests:** when I and D requests arrive together in IDLE with `icount`<`STARVE_MAX`, D is granted. With `icount`==`STARVE_MAX`, I is granted.

## Test plan
- **Reset:** assert `nRST`=0 mid-DACC with `ram_ready`=0 → strobes go to 0 asynchronously. After release: `grant`=00 and `icount`=0, and `ihit` never pulses.
- **Single fetch:** `iREN`=1, `iaddr`=0x40, RAM returns 0x8C010004 with 2 wait states → `ramREN`=1 and `ramaddr`=0x40 in cycles 1–3. In cycle 3, `ihit`=1 and `iload`=0x8C010004. Cycle 4 is IDLE.
- **Data priority:** `iREN`=1 and `dWEN`=1 (`daddr`=0x100, `dstore`=0xDEADBEEF) with zero-wait RAM → `dhit` in cycle 1 with `ramWEN`=1, then IDLE in cycle 2, IACC in cycle 3, `ihit` in cycle 3.
- **Starvation (`STARVE_MAX`=3):** `iREN` held high, `dREN` re-asserted continuously → exactly 3 `dhit`s, then an `ihit`, then D resumes with `icount` back at 0.
- **Abort:** IACC with `ram_ready`=0, then `iREN` dropped → IDLE next cycle, no `ihit`, and a pending `dREN` is granted afterward.
- **Read/write precedence:** `dREN`=`dWEN`=1 → `ramWEN`=1 and `ramREN`=0 throughout DACC.
